// File: rtl/dmem_if.sv
// Request/acknowledge bus between the data-memory controller and a variable-latency memory.
// Valid/ready: mem_req is the valid; mem_ack is the ready/complete strobe; a transfer ends on a cycle with both high.
interface dmem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: stalls the core while a load/store runs over the
// req/ack bus, returns load data, and flags misaligned or timed-out accesses.
module dmem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        err_clr,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err,
  dmem_if.master      mem,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             access;
  logic             misal;
  logic             err_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      readdata_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    err_set    = 1'b0;
    stall      = 1'b0;
    access     = memread | memwrite;
    misal      = access & (addr[1:0] != 2'b00);

    case (state_q)
      IDLE: begin
        // A misaligned access is dropped so the instruction retires without a bus cycle.
        if (misal) begin
          err_set    = 1'b1;
          readdata_d = '0;
        end else if (access) begin
          stall   = 1'b1;
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = writedata;
          we_d    = memwrite;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          if (!we_q) readdata_d = mem.mem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_set    = 1'b1;
          readdata_d = '0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Setting wins over a coincident clear.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign readdata      = readdata_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios with literal expectations, then random
// accesses against an access-level model checked on every falling edge.
module tb_dmem_ctrl;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, err_clr;
  logic [31:0] addr, writedata;
  logic [31:0] readdata;
  logic        stall, err;
  logic [1:0]  dbg_state;

  dmem_if mif();

  dmem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .err_clr   (err_clr),
    .readdata  (readdata),
    .stall     (stall),
    .err       (err),
    .mem       (mif.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An access in flight is described by its age in bus cycles; a finished one
  // leaves a single commit cycle behind it.
  bit          m_busy = 0, m_done = 0, m_we = 0, m_err = 0;
  int          m_age = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;

  always @(posedge clk or negedge reset) begin
    bit set, acc, mis;
    if (!reset) begin
      m_busy = 0; m_done = 0; m_we = 0; m_err = 0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_rd = '0;
    end else begin
      set = 0;
      acc = memread | memwrite;
      mis = acc && (addr % 4 != 0);
      if (m_busy) begin
        if (mif.mem_ack) begin
          if (!m_we) m_rd = mif.mem_rdata;
          m_busy = 0; m_done = 1;
        end else if (m_age + 1 == TIMEOUT) begin
          set = 1; m_rd = '0; m_busy = 0; m_done = 1;
        end else begin
          m_age++;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (mis) begin
        set = 1; m_rd = '0;
      end else if (acc) begin
        m_we = memwrite; m_addr = addr - (addr % 4); m_wdata = writedata;
        m_busy = 1; m_age = 0;
      end
      if (set) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  // ---------------- scoreboard compare ----------------
  logic        e_stall;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_busy)      e_stall = 1'b1;
      else if (m_done) e_stall = 1'b0;
      else             e_stall = (memread | memwrite) && (addr % 4 == 0);
      exp_q.push_back(m_rd);
      chk("stall",     {31'b0, stall},        {31'b0, e_stall});
      chk("mem_req",   {31'b0, mif.mem_req},  {31'b0, m_busy});
      chk("mem_we",    {31'b0, mif.mem_we},   {31'b0, m_we});
      chk("mem_addr",  mif.mem_addr,          m_addr);
      chk("mem_wdata", mif.mem_wdata,         m_wdata);
      chk("readdata",  readdata,              exp_q.pop_front());
      chk("err",       {31'b0, err},          {31'b0, m_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    memread = 0; memwrite = 0; addr = '0; writedata = '0; err_clr = 0;
    mif.mem_ack = 0; mif.mem_rdata = '0;
  endtask

  // Presents one access in the current (IDLE) cycle, acks on bus cycle `lat`
  // (0 = never), returns at the falling edge of the first stall-free cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdat, input int lat,
                           output int stalls, output int reqs, output logic we_seen,
                           output logic [31:0] addr_seen, output logic [31:0] wdata_seen);
    bit ended;
    stalls = 0; reqs = 0; ended = 0;
    we_seen = 0; addr_seen = '0; wdata_seen = '0;
    memread = rd; memwrite = wr; addr = a; writedata = wd;
    mif.mem_ack = 0; mif.mem_rdata = rdat;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (mif.mem_req) reqs++;
      if (c == 1) begin
        we_seen = mif.mem_we; addr_seen = mif.mem_addr; wdata_seen = mif.mem_wdata;
      end
      if (!stall) begin
        ended = 1;
        break;
      end
      @(posedge clk); #1;
      memread = 0; memwrite = 0;
      mif.mem_ack = (lat != 0) && (c + 1 == lat);
    end
    chk("access_ends", {31'b0, ended}, 32'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  int          st, rq, lat;
  logic        wes;
  logic [31:0] as, ws;

  initial begin
    idle_inputs();
    reset = 1;
    #1 reset = 0;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    next_cycle();

    // load with ack on third bus cycle
    do_access(1, 0, 32'h40, 32'h0, 32'h12345678, 3, st, rq, wes, as, ws);
    chk("t1_stalls", st, 4);
    chk("t1_reqs", rq, 3);
    chk("t1_readdata", readdata, 32'h12345678);
    chk("t1_we", {31'b0, wes}, 32'd0);
    next_cycle();

    // store with immediate ack
    do_access(0, 1, 32'h44, 32'hCAFEF00D, 32'h0, 1, st, rq, wes, as, ws);
    chk("t2_stalls", st, 2);
    chk("t2_we", {31'b0, wes}, 32'd1);
    chk("t2_wdata", ws, 32'hCAFEF00D);
    chk("t2_addr", as, 32'h44);
    chk("t2_readdata", readdata, 32'h12345678);
    next_cycle();

    // misaligned load
    do_access(1, 0, 32'h42, 32'h0, 32'h0, 1, st, rq, wes, as, ws);
    chk("t3_stalls", st, 0);
    chk("t3_reqs", rq, 0);
    next_cycle();
    @(negedge clk);
    chk("t3_err", {31'b0, err}, 32'd1);
    chk("t3_readdata", readdata, 32'd0);
    @(posedge clk); #1 err_clr = 1;
    next_cycle();
    @(negedge clk);
    chk("t3_err_clr", {31'b0, err}, 32'd0);
    next_cycle();

    // read+write together is a write; then back-to-back loads
    do_access(1, 1, 32'h48, 32'h01020304, 32'h0, 2, st, rq, wes, as, ws);
    chk("t6_we", {31'b0, wes}, 32'd1);
    chk("t6_addr", as, 32'h48);
    chk("t6_stalls", st, 3);
    next_cycle();
    do_access(1, 0, 32'h4C, 32'h0, 32'hAAAA5555, 1, st, rq, wes, as, ws);
    chk("t6_ld1_stalls", st, 2);
    chk("t6_ld1_data", readdata, 32'hAAAA5555);
    next_cycle();
    do_access(1, 0, 32'h50, 32'h0, 32'h0BADC0DE, 4, st, rq, wes, as, ws);
    chk("t6_ld2_stalls", st, 5);
    chk("t6_ld2_data", readdata, 32'h0BADC0DE);
    next_cycle();

    // timeout
    do_access(1, 0, 32'h80, 32'h0, 32'h0, 0, st, rq, wes, as, ws);
    chk("t4_reqs", rq, TIMEOUT);
    chk("t4_stalls", st, TIMEOUT + 1);
    chk("t4_err", {31'b0, err}, 32'd1);
    chk("t4_readdata", readdata, 32'd0);
    chk("t4_done", {30'b0, dbg_state}, 32'd2);
    next_cycle();
    @(negedge clk);
    chk("t4_idle", {30'b0, dbg_state}, 32'd0);
    next_cycle();

    // reset in the middle of a request, then a stray ack
    do_access(1, 0, 32'h54, 32'h0, 32'h0, 2, st, rq, wes, as, ws);
    chk("t5_pre_data", readdata, 32'h0);
    next_cycle();
    memread = 1; addr = 32'h58;
    @(posedge clk); #1 memread = 0;
    #2 chk("t5_req_up", {31'b0, mif.mem_req}, 32'd1);
    reset = 0;
    #1;
    chk("t5_req_drop", {31'b0, mif.mem_req}, 32'd0);
    chk("t5_state", {30'b0, dbg_state}, 32'd0);
    chk("t5_stall", {31'b0, stall}, 32'd0);
    @(negedge clk) reset = 1;
    @(posedge clk); #1 mif.mem_ack = 1; mif.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t5_late_req", {31'b0, mif.mem_req}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t5_late_data", readdata, 32'd0);
    chk("t5_late_state", {30'b0, dbg_state}, 32'd0);

    // randomized traffic
    lat = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (m_busy) mif.mem_ack = (m_age + 1 == lat);
      else        mif.mem_ack = ($urandom_range(0, 5) == 0);
      mif.mem_rdata = $urandom;
      memread   = ($urandom_range(0, 2) == 0);
      memwrite  = ($urandom_range(0, 3) == 0);
      addr      = $urandom;
      if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
      writedata = $urandom;
      err_clr   = ($urandom_range(0, 9) == 0);
      if (!m_busy) lat = $urandom_range(1, TIMEOUT + 2);
    end
    next_cycle();
    @(negedge clk);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
